// File: rtl/ex_commit_ctrl.sv
// rtl/ex_commit_ctrl.sv - exception/ERTN commit, pipeline flush and fetch redirect sequencer
module ex_commit_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [4:0]  ws_ex_vec,
  input  logic        ws_ertn,
  input  logic        int_pending,
  input  logic        fs_ready,
  output logic        ws_hold,
  output logic        ws_cancel,
  output logic        csr_ex_commit,
  output logic        csr_ertn_commit,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_ex_pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic        redirect_sel,
  output logic        busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  ecode_q, ecode_d;
  logic        ertn_q, ertn_d;
  logic [31:0] pc_q, pc_d;

  logic        evt;
  logic [5:0]  evt_ecode;
  logic        evt_ertn;
  logic        idle;

  assign evt  = ws_valid & (int_pending | (|ws_ex_vec) | ws_ertn);
  assign idle = (state_q == S_IDLE);

  // ertn only wins when nothing else is pending
  always_comb begin
    evt_ecode = 6'h00;
    evt_ertn  = 1'b0;
    if (int_pending)       evt_ecode = 6'h00;
    else if (ws_ex_vec[4]) evt_ecode = 6'h08;
    else if (ws_ex_vec[3]) evt_ecode = 6'h0D;
    else if (ws_ex_vec[2]) evt_ecode = 6'h0B;
    else if (ws_ex_vec[1]) evt_ecode = 6'h0C;
    else if (ws_ex_vec[0]) evt_ecode = 6'h09;
    else                   evt_ertn  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ecode_d = ecode_q;
    ertn_d  = ertn_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (evt) begin
          state_d = S_COMMIT;
          ecode_d = evt_ecode;
          ertn_d  = evt_ertn;
          pc_d    = ws_pc;
        end
      end
      S_COMMIT: begin
        state_d = S_FLUSH;
        cnt_d   = CNT_LOAD;
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_REDIRECT: begin
        if (fs_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ecode_q <= 6'd0;
      ertn_q  <= 1'b0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecode_q <= ecode_d;
      ertn_q  <= ertn_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock
  assign ws_hold         = resetn & (idle ? evt : 1'b1);
  assign ws_cancel       = ws_hold;
  assign csr_ex_commit   = (state_q == S_COMMIT) & ~ertn_q;
  assign csr_ertn_commit = (state_q == S_COMMIT) & ertn_q;
  assign csr_ecode       = idle ? 6'd0 : ecode_q;
  assign csr_esubcode    = 9'd0;
  assign csr_ex_pc       = idle ? 32'd0 : pc_q;
  assign flush           = (state_q == S_COMMIT) | (state_q == S_FLUSH);
  assign redirect_valid  = (state_q == S_REDIRECT);
  assign redirect_sel    = (state_q == S_REDIRECT) & ertn_q;
  assign busy            = ~idle;

endmodule
